serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor that computes A − B − Bin one bit per clock, LSB first, through a single registered-borrow full-subtractor cell. It is the sequential counterpart of the team's combinational full subtractor. It consumes operand words over a valid/ready input handshake and returns difference, borrow-out and signed overflow over a valid/ready output handshake. It is used where area matters more than latency and as the reusable datapath for multi-word subtraction.

---
 rtl/sub_pkg.sv | 13 +
 rtl/fs_cell.sv | 16 +
 rtl/serial_subtractor.sv | 121 ++++++++++++
 tb/tb_serial_subtractor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Holds the controller state encoding and the default operand width.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fs_cell.sv
// One-bit combinational full subtractor: d = a - b - bi, bo = borrow out.
module fs_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bi_i,
    output logic d_o,
    output logic bo_o
);

    logic axb;

    assign axb  = a_i ^ b_i;
    assign d_o  = axb ^ bi_i;
    assign bo_o = (~a_i & b_i) | (~axb & bi_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, one bit per clock, LSB first,
// with valid/ready handshakes on operands and results.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             cell_d;
    logic             cell_bo;

    fs_cell u_fs_cell (
        .a_i  (a_sr_q[0]),
        .b_i  (b_sr_q[0]),
        .bi_i (brw_q),
        .d_o  (cell_d),
        .bo_o (cell_bo)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    diff_d  = '0;
                    bout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // New bits enter at the MSB so bit 0 lands at diff[0] after WIDTH steps.
                diff_d = {cell_d, diff_q[WIDTH-1:1]};
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                brw_d  = cell_bo;
                if (cnt_q == LAST_BIT) begin
                    ovf_d   = brw_q ^ cell_bo;
                    bout_d  = cell_bo;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=2.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;

    logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       in_valid2, in_ready2, bin2, out_valid2, out_ready2, bout2, ovf2;
    logic [1:0] a2, b2, diff2;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .bin       (bin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .diff      (diff8),
        .bout      (bout8),
        .ovf       (ovf8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .bin       (bin2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .diff      (diff2),
        .bout      (bout2),
        .ovf       (ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer arithmetic, unsigned for diff/bout, signed range test for ovf.
    function automatic exp_t model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                   input logic binv);
        exp_t e;
        int   mask, ua, ub, u, sa, sbv, s;
        mask = (1 << w) - 1;
        ua   = int'(av) & mask;
        ub   = int'(bv) & mask;
        u    = ua - ub - int'(binv);
        e.diff = 8'(u & mask);
        e.bout = (u < 0);
        sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sbv  = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        s    = sa - sbv - int'(binv);
        e.ovf = (s < -(1 << (w - 1))) || (s > (1 << (w - 1)) - 1);
        return e;
    endfunction

    function automatic logic get_in_ready(input int w);
        return (w == 8) ? in_ready8 : in_ready2;
    endfunction

    function automatic logic get_out_valid(input int w);
        return (w == 8) ? out_valid8 : out_valid2;
    endfunction

    function automatic exp_t get_result(input int w);
        exp_t r;
        r.diff = (w == 8) ? diff8 : {6'b0, diff2};
        r.bout = (w == 8) ? bout8 : bout2;
        r.ovf  = (w == 8) ? ovf8 : ovf2;
        return r;
    endfunction

    // Accept one operation, wait for its result and check it plus the latency.
    task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                          input logic binv);
        int   cyc;
        exp_t e, got;
        out_ready8 = 1'b1;
        out_ready2 = 1'b1;
        cyc = 0;
        while (!get_in_ready(w) && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (w == 8) begin
            a8 = av; b8 = bv; bin8 = binv; in_valid8 = 1'b1;
        end else begin
            a2 = av[1:0]; b2 = bv[1:0]; bin2 = binv; in_valid2 = 1'b1;
        end
        sb.push_back(model(w, av, bv, binv));
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_valid2 = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!get_out_valid(w) && cyc < 4 * w + 4);
        vectors++;
        if (cyc != w || !get_out_valid(w)) begin
            miscompares++;
            $display("FAIL latency w=%0d a=%h b=%h: got %0d edges, want %0d", w, av, bv, cyc, w);
        end
        e   = sb.pop_front();
        got = get_result(w);
        vectors++;
        if (got.diff !== e.diff) begin
            miscompares++;
            $display("FAIL diff w=%0d a=%h b=%h bin=%b: got %h want %h", w, av, bv, binv,
                     got.diff, e.diff);
        end
        vectors++;
        if (got.bout !== e.bout) begin
            miscompares++;
            $display("FAIL bout w=%0d a=%h b=%h bin=%b: got %b want %b", w, av, bv, binv,
                     got.bout, e.bout);
        end
        vectors++;
        if (got.ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL ovf w=%0d a=%h b=%h bin=%b: got %b want %b", w, av, bv, binv,
                     got.ovf, e.ovf);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (get_in_ready(w) !== 1'b1 || get_out_valid(w) !== 1'b0) begin
            miscompares++;
            $display("FAIL handshake_return w=%0d: in_ready=%b out_valid=%b want 1/0", w,
                     get_in_ready(w), get_out_valid(w));
        end
    endtask

    task automatic check_idle(input string tag);
        vectors++;
        if ({in_ready8, out_valid8, diff8, bout8, ovf8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL %s: in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b want 1 0 00 0 0",
                     tag, in_ready8, out_valid8, diff8, bout8, ovf8);
        end
        vectors++;
        if ({in_ready2, out_valid2, diff2, bout2, ovf2} !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL %s_w2: in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b want 1 0 0 0 0",
                     tag, in_ready2, out_valid2, diff2, bout2, ovf2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; out_ready8 = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_held");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("reset_released");
    endtask

    task automatic test_basic();
        run_op(8, 8'h05, 8'h03, 1'b0);
        run_op(8, 8'h00, 8'h01, 1'b0);
        run_op(8, 8'h80, 8'h01, 1'b0);
        run_op(8, 8'h10, 8'h0F, 1'b1);
        run_op(8, 8'h7F, 8'hFF, 1'b1);
        run_op(8, 8'h80, 8'h7F, 1'b1);
    endtask

    task automatic test_backpressure();
        int   cyc;
        exp_t e;
        out_ready8 = 1'b0;
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; in_valid8 = 1'b1;
        sb.push_back(model(8, 8'h33, 8'h11, 1'b0));
        @(posedge clk);
        #1;
        // Keep offering different operands; they must not be taken.
        a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid8 && cyc < 40);
        vectors++;
        if (cyc != 8 || !out_valid8) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d edges, want 8", cyc);
        end
        e = sb[0];
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({out_valid8, in_ready8} !== 2'b10) begin
                miscompares++;
                $display("FAIL bp_hold_flags cycle %0d: out_valid=%b in_ready=%b want 1 0", i,
                         out_valid8, in_ready8);
            end
            vectors++;
            if ({diff8, bout8, ovf8} !== {e.diff, e.bout, e.ovf}) begin
                miscompares++;
                $display("FAIL bp_hold_data cycle %0d: got %h/%b/%b want %h/%b/%b", i, diff8,
                         bout8, ovf8, e.diff, e.bout, e.ovf);
            end
            @(posedge clk);
            #1;
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        vectors++;
        if ({in_ready8, out_valid8} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready8, out_valid8);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready8 !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_no_stray_accept: in_ready=%b want 1", in_ready8);
        end
    endtask

    task automatic test_reset_mid();
        a8 = 8'h5A; b8 = 8'h21; bin8 = 1'b1; in_valid8 = 1'b1;
        sb.push_back(model(8, 8'h5A, 8'h21, 1'b1));
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        vectors++;
        if ({in_ready8, out_valid8, diff8, bout8, ovf8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b want 1 0 00 0 0",
                     in_ready8, out_valid8, diff8, bout8, ovf8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(8, 8'h7F, 8'hFF, 1'b0);
    endtask

    task automatic test_exhaustive_w2();
        logic [4:0] v;
        for (int i = 0; i < 32; i++) begin
            v = 5'(i);
            run_op(2, {6'b0, v[4:3]}, {6'b0, v[2:1]}, v[0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            run_op(8, 8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_exhaustive_w2();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
